// File: rtl/rf_write_arb.sv
// rf_write_arb: shares the single register-file write port between two
// writeback requesters (req0 = execute, req1 = load). Each requester has a
// one-entry holding buffer. A round-robin arbiter picks between the full
// buffers, and the winner is written through registered rf_* outputs. An
// NREG-bit busy scoreboard tracks destinations with writes in flight.
// Optional build macro RF_ARB_STATS_EN adds the conflict_cnt statistics output.
module rf_write_arb #(
  parameter int NREG = 8,
  parameter int DW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [2:0]      req0_reg,
  input  logic [DW-1:0]   req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [2:0]      req1_reg,
  input  logic [DW-1:0]   req1_data,
  output logic            req1_ready,
  input  logic            busy_set,
  input  logic [2:0]      busy_set_reg,
  output logic [NREG-1:0] busy,
  output logic            rf_write,
  output logic [2:0]      rf_writeregsel,
  output logic [DW-1:0]   rf_writedata,
  output logic            err
`ifdef RF_ARB_STATS_EN
  ,
  output logic [7:0]      conflict_cnt
`endif
);

  localparam int NUM_REQ = 2;
  localparam int RW      = 3;

  // One buffered writeback: destination register plus data.
  typedef struct packed {
    logic [RW-1:0] rsel;
    logic [DW-1:0] data;
  } wb_req_t;

  logic    [NUM_REQ-1:0] in_valid;
  logic    [NUM_REQ-1:0] in_ready;
  logic    [NUM_REQ-1:0] take;
  logic    [NUM_REQ-1:0] grant;
  logic    [NUM_REQ-1:0] buf_full_q, buf_full_d;
  wb_req_t [NUM_REQ-1:0] in_req;
  wb_req_t [NUM_REQ-1:0] buf_q, buf_d;

  wb_req_t               gnt_req;
  logic                  gnt_any;
  logic                  last_grant_q, last_grant_d;

  logic                  rf_write_q, rf_write_d;
  logic    [RW-1:0]      sel_q, sel_d;
  logic    [DW-1:0]      wdata_q, wdata_d;

  logic    [NREG-1:0]    busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  set_is_clr;
  logic                  waw_hit;
  logic                  stale_wr;

  // Requester ports gathered into per-lane packed arrays.
  assign in_valid   = {req1_valid, req0_valid};
  assign in_req[0]  = '{rsel: req0_reg, data: req0_data};
  assign in_req[1]  = '{rsel: req1_reg, data: req1_data};
  assign req0_ready = in_ready[0];
  assign req1_ready = in_ready[1];

  // Per-requester holding buffer. A buffer accepts a new entry when it is
  // empty or when its current entry is leaving this very edge, so a granted
  // requester can stream back-to-back without a bubble.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign in_ready[i]   = ~buf_full_q[i] | grant[i];
    assign take[i]       = in_valid[i] & in_ready[i];
    assign buf_full_d[i] = take[i] | (buf_full_q[i] & ~grant[i]);
    assign buf_d[i]      = take[i] ? in_req[i] : buf_q[i];
  end

  // Round-robin arbiter: a lone full buffer wins outright; when both are
  // full, the one that did not win last time goes.
  always_comb begin
    grant = buf_full_q;
    if (&buf_full_q) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end
  end

  assign gnt_any      = |grant;
  assign gnt_req      = grant[1] ? buf_q[1] : buf_q[0];
  assign last_grant_d = gnt_any ? grant[1] : last_grant_q;

  // Write stage: pulse rf_write on a grant; sel/data hold between writes.
  always_comb begin
    rf_write_d = gnt_any;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    if (gnt_any) begin
      sel_d   = gnt_req.rsel;
      wdata_d = gnt_req.data;
    end
  end

  // Scoreboard and sticky error. The clear is applied before the set so a
  // same-edge issue to the register being written leaves it pending; that
  // case is a fresh issue, not a WAW, so it does not raise err.
  always_comb begin
    set_is_clr = gnt_any & (gnt_req.rsel == busy_set_reg);
    waw_hit    = busy_set & busy_q[busy_set_reg] & ~set_is_clr;
    stale_wr   = gnt_any & ~busy_q[gnt_req.rsel];
    busy_d     = busy_q;
    if (gnt_any) begin
      busy_d[gnt_req.rsel] = 1'b0;
    end
    if (busy_set) begin
      busy_d[busy_set_reg] = 1'b1;
    end
    err_d = err_q | waw_hit | stale_wr;
  end

  // All arbiter, buffer, write-port and scoreboard state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_full_q   <= '0;
      buf_q        <= '0;
      last_grant_q <= 1'b1;
      rf_write_q   <= 1'b0;
      sel_q        <= '0;
      wdata_q      <= '0;
      busy_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      buf_full_q   <= buf_full_d;
      buf_q        <= buf_d;
      last_grant_q <= last_grant_d;
      rf_write_q   <= rf_write_d;
      sel_q        <= sel_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign rf_write       = rf_write_q;
  assign rf_writeregsel = sel_q;
  assign rf_writedata   = wdata_q;
  assign busy           = busy_q;
  assign err            = err_q;

`ifdef RF_ARB_STATS_EN
  logic [7:0] cnt_q, cnt_d;

  // Count cycles where both buffers are contending; saturate at 8'hFF.
  always_comb begin
    cnt_d = cnt_q;
    if ((&buf_full_q) && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Conflict counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rf_write_arb.sv
// Directed testbench for rf_write_arb. Inputs change on the falling edge,
// outputs are sampled on the falling edge after each rising edge.
module tb_rf_write_arb;
  localparam int DW   = 16;
  localparam int NREG = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req1_valid;
  logic [2:0]      req0_reg, req1_reg;
  logic [DW-1:0]   req0_data, req1_data;
  logic            req0_ready, req1_ready;
  logic            busy_set;
  logic [2:0]      busy_set_reg;
  logic [NREG-1:0] busy;
  logic            rf_write;
  logic [2:0]      rf_writeregsel;
  logic [DW-1:0]   rf_writedata;
  logic            err;
`ifdef RF_ARB_STATS_EN
  logic [7:0]      conflict_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_write_arb #(.NREG(NREG), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req0_valid     (req0_valid),
    .req0_reg       (req0_reg),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_reg       (req1_reg),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .busy_set       (busy_set),
    .busy_set_reg   (busy_set_reg),
    .busy           (busy),
    .rf_write       (rf_write),
    .rf_writeregsel (rf_writeregsel),
    .rf_writedata   (rf_writedata),
    .err            (err)
`ifdef RF_ARB_STATS_EN
    ,
    .conflict_cnt   (conflict_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    busy_set   = 1'b0;
  endtask

  // One rising edge, returning at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int n0, n1, low0, low1, max0, max1, sel;
    logic h0, h1;

    idle();
    req0_reg = '0; req0_data = '0; req1_reg = '0; req1_data = '0; busy_set_reg = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);

    // ---- reset state ----
    chk("rst_rf_write", 32'(rf_write), 32'd0);
    chk("rst_sel", 32'(rf_writeregsel), 32'd0);
    chk("rst_data", 32'(rf_writedata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd1);
    chk("rst_ready1", 32'(req1_ready), 32'd1);
    rst = 1'b1;

    // ---- single uncontested write r3=BEEF ----
    busy_set = 1'b1; busy_set_reg = 3'd3;
    step();
    busy_set = 1'b0;
    chk("t1_busy_set", 32'(busy), 32'h08);
    req0_valid = 1'b1; req0_reg = 3'd3; req0_data = 16'hBEEF;
    step();                                   // handshake edge
    req0_valid = 1'b0;
    chk("t1_no_write_yet", 32'(rf_write), 32'd0);
    step();                                   // grant edge
    chk("t1_write", 32'(rf_write), 32'd1);
    chk("t1_sel", 32'(rf_writeregsel), 32'd3);
    chk("t1_data", 32'(rf_writedata), 32'hBEEF);
    chk("t1_busy_clr", 32'(busy), 32'h00);
    chk("t1_err", 32'(err), 32'd0);
    step();
    chk("t1_pulse_end", 32'(rf_write), 32'd0);
    chk("t1_sel_hold", 32'(rf_writeregsel), 32'd3);
    chk("t1_data_hold", 32'(rf_writedata), 32'hBEEF);

    // ---- same-edge handshake, req0 first after reset ----
    do_reset();
    busy_set = 1'b1; busy_set_reg = 3'd1;
    step();
    busy_set_reg = 3'd2;
    step();
    busy_set = 1'b0;
    chk("t2_busy", 32'(busy), 32'h06);
    req0_valid = 1'b1; req0_reg = 3'd1; req0_data = 16'h1111;
    req1_valid = 1'b1; req1_reg = 3'd2; req1_data = 16'h2222;
    step();
    idle();
    chk("t2_idle", 32'(rf_write), 32'd0);
    step();
    chk("t2_first_wr", 32'(rf_write), 32'd1);
    chk("t2_first_sel", 32'(rf_writeregsel), 32'd1);
    chk("t2_first_data", 32'(rf_writedata), 32'h1111);
    chk("t2_busy_mid", 32'(busy), 32'h04);
    step();
    chk("t2_second_wr", 32'(rf_write), 32'd1);
    chk("t2_second_sel", 32'(rf_writeregsel), 32'd2);
    chk("t2_second_data", 32'(rf_writedata), 32'h2222);
    step();
    chk("t2_done", 32'(rf_write), 32'd0);
    chk("t2_busy_end", 32'(busy), 32'h00);
    chk("t2_err", 32'(err), 32'd0);

    // ---- sustained contention: req0 -> r0,2,4,6  req1 -> r1,3,5,7 ----
    busy_set = 1'b1;
    for (int r = 0; r < 8; r++) begin
      busy_set_reg = 3'(r);
      step();
    end
    busy_set = 1'b0;
    chk("t3_busy_all", 32'(busy), 32'hFF);
    n0 = 0; n1 = 0; low0 = 0; low1 = 0; max0 = 0; max1 = 0;
    for (int c = 0; c <= 10; c++) begin
      if (c >= 1) begin
        chk("t3_wr", 32'(rf_write), (c >= 2 && c <= 9) ? 32'd1 : 32'd0);
        if (c >= 2 && c <= 9) begin
          sel = c - 2;
          chk("t3_sel", 32'(rf_writeregsel), 32'(sel));
          chk("t3_data", 32'(rf_writedata),
              32'(((sel % 2) == 0 ? 16'hA000 : 16'hB000) + 16'(sel / 2)));
        end
      end
      req0_valid = (n0 < 4); req0_reg = 3'(2 * n0);     req0_data = 16'hA000 + 16'(n0);
      req1_valid = (n1 < 4); req1_reg = 3'(2 * n1 + 1); req1_data = 16'hB000 + 16'(n1);
      #1;
      h0 = req0_valid & req0_ready;
      h1 = req1_valid & req1_ready;
      low0 = (req0_valid && !req0_ready) ? low0 + 1 : 0;
      low1 = (req1_valid && !req1_ready) ? low1 + 1 : 0;
      if (low0 > max0) max0 = low0;
      if (low1 > max1) max1 = low1;
      step();
      if (h0) n0++;
      if (h1) n1++;
    end
    idle();
    chk("t3_n0", 32'(n0), 32'd4);
    chk("t3_n1", 32'(n1), 32'd4);
    chk("t3_max_low0", 32'(max0), 32'd1);
    chk("t3_max_low1", 32'(max1), 32'd1);
    chk("t3_busy_end", 32'(busy), 32'h00);
    chk("t3_err", 32'(err), 32'd0);

    // ---- busy_set r5 on the grant edge of r5 ----
    busy_set = 1'b1; busy_set_reg = 3'd5;
    req0_valid = 1'b1; req0_reg = 3'd5; req0_data = 16'h5555;
    step();
    req0_valid = 1'b0;                        // busy_set r5 stays for grant edge
    step();
    idle();
    chk("t4_wr", 32'(rf_write), 32'd1);
    chk("t4_sel", 32'(rf_writeregsel), 32'd5);
    chk("t4_busy", 32'(busy), 32'h20);
    chk("t4_err", 32'(err), 32'd0);

    // ---- WAW busy_set r4 twice -> sticky err ----
    busy_set = 1'b1; busy_set_reg = 3'd4;
    step();
    chk("t5_no_err_first", 32'(err), 32'd0);
    step();
    idle();
    chk("t5_waw_err", 32'(err), 32'd1);
    chk("t5_busy", 32'(busy), 32'h30);
    step(); step(); step();
    chk("t5_err_sticky", 32'(err), 32'd1);
    rst = 1'b0;
    #1;
    chk("t5_err_async_clr", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    // write to non-busy r6
    req1_valid = 1'b1; req1_reg = 3'd6; req1_data = 16'h6666;
    step();
    idle();
    chk("t5_err_pre_grant", 32'(err), 32'd0);
    step();
    chk("t5_stale_wr", 32'(rf_write), 32'd1);
    chk("t5_stale_sel", 32'(rf_writeregsel), 32'd6);
    chk("t5_stale_err", 32'(err), 32'd1);

    // ---- reset with both buffers full ----
    do_reset();
    busy_set = 1'b1; busy_set_reg = 3'd0;
    step();
    busy_set_reg = 3'd1;
    step();
    busy_set = 1'b0;
    req0_valid = 1'b1; req0_reg = 3'd0; req0_data = 16'h0A0A;
    req1_valid = 1'b1; req1_reg = 3'd1; req1_data = 16'h1B1B;
    step();
    req1_valid = 1'b0;
    req0_reg = 3'd2; req0_data = 16'h2C2C;
    step();
    idle();
    chk("t6_pre_wr", 32'(rf_write), 32'd1);
    chk("t6_pre_sel", 32'(rf_writeregsel), 32'd0);
    chk("t6_pre_data", 32'(rf_writedata), 32'h0A0A);
    chk("t6_pre_busy", 32'(busy), 32'h02);
    chk("t6_pre_full", 32'({req0_ready, req1_ready}), 32'b01);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_wr", 32'(rf_write), 32'd0);
    chk("t6_rst_sel", 32'(rf_writeregsel), 32'd0);
    chk("t6_rst_data", 32'(rf_writedata), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_err", 32'(err), 32'd0);
    chk("t6_rst_ready", 32'({req0_ready, req1_ready}), 32'b11);
`ifdef RF_ARB_STATS_EN
    chk("t6_rst_cnt", 32'(conflict_cnt), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t6_no_wr_after_rst", 32'(rf_write), 32'd0);
    end

`ifdef RF_ARB_STATS_EN
    // ---- conflict counter ramp and saturation ----
    do_reset();
    req0_valid = 1'b1; req0_reg = 3'd0; req0_data = 16'h0001;
    req1_valid = 1'b1; req1_reg = 3'd1; req1_data = 16'h0002;
    for (int k = 0; k < 10; k++) step();
    chk("st_cnt_9", 32'(conflict_cnt), 32'd9);
    for (int k = 0; k < 300; k++) step();
    chk("st_cnt_sat", 32'(conflict_cnt), 32'hFF);
    idle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_write_arb.md
Name: rf_write_arb

Overview:
- Shares the single write port of the 8x16 register file between two writeback requesters: req0 (ALU/execute) and req1 (load/memory).
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- Round-robin arbitration drives registered write-port outputs.
- An 8-bit busy scoreboard tracks registers with writes in flight, for the hazard/stall logic.

Parameters:
- NREG, 8, number of architectural registers (busy vector width; regsel width fixed at 3).
- DW, 16, write data width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a write.
- req0_reg  in  3  requester 0 destination register.
- req0_data  in  DW  requester 0 write data.
- req0_ready  out  1  requester 0 may hand over this cycle.
- req1_valid, req1_reg, req1_data, req1_ready: same as req0 for requester 1.
- busy_set  in  1  issue marks a destination register pending.
- busy_set_reg  in  3  register to mark.
- busy  out  NREG  pending-write bit per register.
- rf_write  out  1  to register file write enable.
- rf_writeregsel  out  3  to register file write select.
- rf_writedata  out  DW  to register file write data.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst=0, asynchronous):
  - Both buffers empty, busy=0, rf_write=0, rf_writeregsel=0, rf_writedata=0, err=0.
  - last_grant=1, so req0 wins the first conflict.
- Handshake:
  - reqN_ready = ~bufN_full | grantN (combinational).
  - Transfer when valid&ready at the edge; the buffer captures reg and data.
  - valid without ready: the requester holds reg and data stable.
- Arbitration (combinational from buffer state):
  - Neither full: no grant.
  - One full: grant it.
  - Both full: grant the buffer ~= last_grant.
  - last_grant updates only on a grant.
- Write stage (registered), at the edge where bufN is granted:
  - rf_write<=1, rf_writeregsel<=bufN_reg, rf_writedata<=bufN_data.
  - bufN empties unless refilled by a same-edge handshake.
  - No grant: rf_write<=0, and sel/data hold their last values.
- Latency and throughput:
  - Handshake at edge E0, uncontested: rf_write high in the cycle after E1.
  - Sustained throughput is one write per cycle total.
  - Each requester gets at least one write every 2 cycles under contention.
- Scoreboard:
  - busy_set sets busy[busy_set_reg].
  - A grant of register r clears busy[r] at the grant edge.
  - Same-edge set and clear of the same r: set wins (a new issue to r).
  - Grants from both buffers for the same r are serialized; each clears the bit.
- err (sticky until reset), set on:
  - busy_set to a register already busy (WAW, not supported); or
  - a granted write to a register whose busy bit is 0.
  - The write or set still proceeds.
- Reset mid-operation drops buffered writes, with no rf_write pulse.

Optional Feature:
- Macro: RF_ARB_STATS_EN.
- Defined:
  - Adds output conflict_cnt[7:0], reset 0.
  - Increments on each cycle both buffers are full.
  - Saturates at 8'hFF and does not wrap.
- Undefined: no port and no counter logic; all other behaviour identical.

Test Plan:
- Reset, then busy_set r3; one cycle later req0 writes r3=16'hBEEF. Required: rf_write=1, sel=3, data=BEEF exactly 2 cycles after the handshake; busy[3] 1->0; err=0.
- busy_set r1 and r2; req0 (r1=0x1111) and req1 (r2=0x2222) handshake on the same edge. Required: req0 written first, req1 next cycle; busy returns to 0.
- Both requesters valid every cycle for 8 cycles, with all targets pre-marked busy. Required: grants strictly alternate 0,1,0,1…; rf_write stays high continuously; each ready never low more than 1 cycle.
- busy_set r5 on the same edge as a grant of r5. Required: busy[5]=1 afterwards; err=0.
- busy_set r4 twice, with no intervening write. Required: err=1, and it stays 1 until rst=0. Separately, a write to non-busy r6 sets err.
- rst asserted while both buffers are full. Required: all outputs 0 immediately (asynchronous) and no later rf_write. With RF_ARB_STATS_EN, conflict_cnt=0 and after 300 conflict cycles it reads 8'hFF.
